mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_if_pkg.sv | 19 +
 rtl/sp_ram.sv | 21 ++
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared state encoding and default parameters for the memory responder.
package mem_if_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_RESP,
    S_RD_DRAIN,
    S_WR_WAIT,
    S_WR_RESP,
    S_WR_DRAIN
  } state_t;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_RD_LATENCY  = 2;
  localparam int DEF_WR_LATENCY  = 1;
  localparam int LAT_W           = 4;

endpackage

// File: rtl/sp_ram.sv
// Single-port 32-bit word store: synchronous write, combinational read of the same address.
module sp_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory target with level request / pulse accept and four-phase response handshakes.
// One transaction in flight; read data presented RD_LATENCY cycles after the accept pulse.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int RD_LATENCY  = DEF_RD_LATENCY,
  parameter int WR_LATENCY  = DEF_WR_LATENCY
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        axi_rd_rq,
  output logic        axi_rd_rq_ack,
  input  logic [31:0] axi_rd_addr,
  output logic [31:0] axi_rd_data,
  output logic        axi_rd_valid,
  input  logic        axi_rd_valid_ack,
  input  logic        axi_wr_rq,
  output logic        axi_wr_rq_ack,
  input  logic [31:0] axi_wr_addr,
  input  logic [31:0] axi_wr_data,
  output logic        axi_wr_done,
  input  logic        axi_wr_done_ack,
  input  logic        axi_id,
  output logic        rsp_id,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t           state_q;
  logic [LAT_W-1:0] cnt_q;
  logic [AW-1:0]    addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rd_data_q;
  logic             armed_q;
  logic             rd_ack_q;
  logic             wr_ack_q;
  logic             rd_valid_q;
  logic             wr_done_q;
  logic             rsp_id_q;
  logic             busy_q;

  logic             ram_we;
  logic [31:0]      ram_rdata;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{axi_rd_addr[31:AW+2], axi_rd_addr[1:0],
                              axi_wr_addr[31:AW+2], axi_wr_addr[1:0]};

  // Reset in the commit cycle must keep the pending write out of storage.
  assign ram_we = (state_q == S_WR_WAIT) && (cnt_q == '0) && !i_rst;

  sp_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_ram (
    .clk_i  (i_clk),
    .we_i   (ram_we),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      armed_q    <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (axi_rd_rq) begin
            addr_q   <= axi_rd_addr[AW+1:2];
            rsp_id_q <= axi_id;
            rd_ack_q <= 1'b1;
            cnt_q    <= LAT_W'(RD_LATENCY);
            busy_q   <= 1'b1;
            state_q  <= S_RD_WAIT;
          end else if (axi_wr_rq) begin
            addr_q   <= axi_wr_addr[AW+1:2];
            wdata_q  <= axi_wr_data;
            rsp_id_q <= axi_id;
            wr_ack_q <= 1'b1;
            cnt_q    <= LAT_W'(WR_LATENCY);
            busy_q   <= 1'b1;
            state_q  <= S_WR_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (cnt_q == '0) begin
            rd_data_q  <= ram_rdata;
            rd_valid_q <= 1'b1;
            // An ack still high from earlier must fall before it can complete this response.
            armed_q    <= !axi_rd_valid_ack;
            state_q    <= S_RD_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RD_RESP: begin
          if (!axi_rd_valid_ack) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            state_q    <= S_RD_DRAIN;
          end
        end
        S_RD_DRAIN: begin
          if (!axi_rd_valid_ack) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_WR_WAIT: begin
          if (cnt_q == '0) begin
            wr_done_q <= 1'b1;
            armed_q   <= !axi_wr_done_ack;
            state_q   <= S_WR_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WR_RESP: begin
          if (!axi_wr_done_ack) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            wr_done_q <= 1'b0;
            state_q   <= S_WR_DRAIN;
          end
        end
        S_WR_DRAIN: begin
          if (!axi_wr_done_ack) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign axi_rd_rq_ack = rd_ack_q;
  assign axi_wr_rq_ack = wr_ack_q;
  assign axi_rd_valid  = rd_valid_q;
  assign axi_rd_data   = rd_data_q;
  assign axi_wr_done   = wr_done_q;
  assign rsp_id        = rsp_id_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scenario bench for mem_responder: reference word model plus a queue of expected read responses.
module tb_mem_responder;

  localparam int DW = 256;
  localparam int RL = 2;
  localparam int WL = 1;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        axi_rd_rq, axi_rd_rq_ack, axi_rd_valid, axi_rd_valid_ack;
  logic [31:0] axi_rd_addr, axi_rd_data;
  logic        axi_wr_rq, axi_wr_rq_ack, axi_wr_done, axi_wr_done_ack;
  logic [31:0] axi_wr_addr, axi_wr_data;
  logic        axi_id, rsp_id, busy;

  always #5 i_clk = ~i_clk;

  mem_responder #(
    .DEPTH_WORDS(DW),
    .RD_LATENCY (RL),
    .WR_LATENCY (WL)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .axi_rd_rq       (axi_rd_rq),
    .axi_rd_rq_ack   (axi_rd_rq_ack),
    .axi_rd_addr     (axi_rd_addr),
    .axi_rd_data     (axi_rd_data),
    .axi_rd_valid    (axi_rd_valid),
    .axi_rd_valid_ack(axi_rd_valid_ack),
    .axi_wr_rq       (axi_wr_rq),
    .axi_wr_rq_ack   (axi_wr_rq_ack),
    .axi_wr_addr     (axi_wr_addr),
    .axi_wr_data     (axi_wr_data),
    .axi_wr_done     (axi_wr_done),
    .axi_wr_done_ack (axi_wr_done_ack),
    .axi_id          (axi_id),
    .rsp_id          (rsp_id),
    .busy            (busy)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DW];
  exp_t        sb [$];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Returns ticks taken until the chosen output reaches level; limit+1 means it never did.
  task automatic wait_for(input int which, input logic level, input int limit, output int n);
    logic v;
    n = 0;
    do begin
      tick();
      n++;
      case (which)
        0:       v = axi_rd_rq_ack;
        1:       v = axi_rd_valid;
        2:       v = axi_wr_rq_ack;
        default: v = axi_wr_done;
      endcase
    end while (v !== level && n <= limit);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic id);
    int n;
    axi_wr_addr = addr; axi_wr_data = data; axi_id = id; axi_wr_rq = 1'b1;
    wait_for(2, 1'b1, 20, n);
    axi_wr_rq = 1'b0;
    checks++;
    if (n !== 1) begin errors++; $display("FAIL wr_ack_latency got %0d exp 1", n); end
    model[widx(addr)] = data;
    wait_for(3, 1'b1, 40, n);
    checks++;
    if (n !== WL + 1) begin errors++; $display("FAIL wr_done_latency got %0d exp %0d", n, WL + 1); end
    checks++;
    if (rsp_id !== id) begin errors++; $display("FAIL wr_rsp_id got %b exp %b", rsp_id, id); end
    axi_wr_done_ack = 1'b1;
    tick();
    checks++;
    if (axi_wr_done !== 1'b0) begin errors++; $display("FAIL wr_done_drop got %b exp 0", axi_wr_done); end
    axi_wr_done_ack = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle_busy got %b exp 0", busy); end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic id, input int hold, input bit stale);
    int   n;
    exp_t e;
    e.id = id;
    e.data = model[widx(addr)];
    sb.push_back(e);
    axi_rd_addr = addr; axi_id = id; axi_rd_rq = 1'b1;
    if (stale) axi_rd_valid_ack = 1'b1;
    wait_for(0, 1'b1, 20, n);
    axi_rd_rq = 1'b0;
    checks++;
    if (n !== 1) begin errors++; $display("FAIL rd_ack_latency got %0d exp 1", n); end
    tick();
    checks++;
    if ({axi_rd_rq_ack, axi_rd_valid, axi_rd_data} !== 34'd0) begin
      errors++;
      $display("FAIL rd_ack_pulse got ack=%b vld=%b data=%h exp all 0", axi_rd_rq_ack, axi_rd_valid, axi_rd_data);
    end
    // Together with the tick above this makes valid 1+RL cycles after the ack.
    wait_for(1, 1'b1, 40, n);
    checks++;
    if (n !== RL) begin errors++; $display("FAIL rd_valid_latency got %0d exp %0d", n + 1, RL + 1); end
    e = sb.pop_front();
    checks++;
    if (axi_rd_data !== e.data) begin errors++; $display("FAIL rd_data got %h exp %h", axi_rd_data, e.data); end
    checks++;
    if (rsp_id !== e.id) begin errors++; $display("FAIL rd_rsp_id got %b exp %b", rsp_id, e.id); end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (axi_rd_valid !== 1'b1 || axi_rd_data !== e.data || rsp_id !== e.id) begin
        errors++;
        $display("FAIL rd_hold cyc %0d got vld=%b data=%h id=%b exp 1 %h %b",
                 i, axi_rd_valid, axi_rd_data, rsp_id, e.data, e.id);
      end
    end
    if (stale) begin
      axi_rd_valid_ack = 1'b0;
      tick();
      checks++;
      if (axi_rd_valid !== 1'b1) begin errors++; $display("FAIL rd_stale_rearm got %b exp 1", axi_rd_valid); end
    end
    axi_rd_valid_ack = 1'b1;
    tick();
    checks++;
    if (axi_rd_valid !== 1'b0 || axi_rd_data !== 32'd0) begin
      errors++;
      $display("FAIL rd_valid_drop got vld=%b data=%h exp 0 0", axi_rd_valid, axi_rd_data);
    end
    axi_rd_valid_ack = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle_busy got %b exp 0", busy); end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({axi_rd_rq_ack, axi_wr_rq_ack, axi_rd_valid, axi_wr_done, axi_rd_data, rsp_id, busy} !== 38'd0) begin
      errors++;
      $display("FAIL %s got rack=%b wack=%b vld=%b done=%b data=%h id=%b busy=%b exp all 0", tag,
               axi_rd_rq_ack, axi_wr_rq_ack, axi_rd_valid, axi_wr_done, axi_rd_data, rsp_id, busy);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    axi_rd_rq = 0; axi_wr_rq = 0; axi_rd_valid_ack = 0; axi_wr_done_ack = 0;
    axi_rd_addr = 0; axi_wr_addr = 0; axi_wr_data = 0; axi_id = 0;
    repeat (3) tick();
    check_all_zero("reset_state");
    i_rst = 1'b0;
    tick();
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_write_read();
    do_write(32'h40, 32'hDEADBEEF, 1'b0);
    do_read(32'h40, 1'b0, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_write(32'h44, 32'hCAFE0044, 1'b0);
    do_read(32'h44, 1'b0, 10, 1'b0);
  endtask

  task automatic test_alias();
    do_write(32'h3, 32'h12345678, 1'b0);
    do_read(32'h400, 1'b0, 0, 1'b0);
    do_read(32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_collision();
    int n;
    do_write(32'h10, 32'h11110010, 1'b0);
    axi_rd_addr = 32'h10; axi_wr_addr = 32'h20; axi_wr_data = 32'h22220020; axi_id = 1'b0;
    axi_rd_rq = 1'b1; axi_wr_rq = 1'b1;
    tick();
    axi_rd_rq = 1'b0;
    checks++;
    if (axi_rd_rq_ack !== 1'b1 || axi_wr_rq_ack !== 1'b0) begin
      errors++;
      $display("FAIL coll_rd_first got rack=%b wack=%b exp 1 0", axi_rd_rq_ack, axi_wr_rq_ack);
    end
    wait_for(1, 1'b1, 40, n);
    checks++;
    if (axi_rd_data !== 32'h11110010 || axi_wr_rq_ack !== 1'b0) begin
      errors++;
      $display("FAIL coll_rd_data got %h wack=%b exp 11110010 0", axi_rd_data, axi_wr_rq_ack);
    end
    axi_rd_valid_ack = 1'b1;
    tick();
    axi_rd_valid_ack = 1'b0;
    // One edge leaves DRAIN, the next (in IDLE) accepts the pending write.
    wait_for(2, 1'b1, 20, n);
    axi_wr_rq = 1'b0;
    checks++;
    if (n !== 2) begin errors++; $display("FAIL coll_wr_ack_delay got %0d exp 2", n); end
    model[widx(32'h20)] = 32'h22220020;
    wait_for(3, 1'b1, 40, n);
    checks++;
    if (n !== WL + 1) begin errors++; $display("FAIL coll_wr_done got %0d exp %0d", n, WL + 1); end
    axi_wr_done_ack = 1'b1;
    tick();
    axi_wr_done_ack = 1'b0;
    tick();
    do_read(32'h20, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_in_write();
    int n;
    do_write(32'h80, 32'hA5A5A5A5, 1'b1);
    axi_wr_addr = 32'h80; axi_wr_data = 32'h5A5A5A5A; axi_id = 1'b1; axi_wr_rq = 1'b1;
    wait_for(2, 1'b1, 20, n);
    axi_wr_rq = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || axi_wr_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_wait got busy=%b done=%b exp 1 0", busy, axi_wr_done);
    end
    i_rst = 1'b1;
    tick();
    check_all_zero("rst_in_write");
    i_rst = 1'b0;
    tick();
    do_read(32'h80, 1'b0, 0, 1'b0);
  endtask

  task automatic test_id_stale_ack();
    do_write(32'h90, 32'h0BADF00D, 1'b0);
    do_read(32'h90, 1'b1, 3, 1'b0);
    do_read(32'h90, 1'b0, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, hi;
    for (int i = 0; i < 6; i++) begin
      a = {24'd0, 2'b00, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))} + 32'h100;
      d = $urandom;
      do_write(a, d, 1'($urandom_range(0, 1)));
      hi = 32'($urandom) & 32'hFFFF_FC00;
      do_read(a | hi, 1'($urandom_range(0, 1)), 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stall();
    test_alias();
    test_collision();
    test_reset_in_write();
    test_id_stale_ack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
